shift_deserializer: RTL and testbench

- Serial-to-parallel stage that sits directly downstream of the team's shift register.
- Consumes its serial bit stream (o_shift qualified by o_valid) and rebuilds BUS_WIDTH-bit words.
- Presents each completed word on a valid/ready output port to the next parallel consumer.
- The serial source has no backpressure. A completed word that cannot be delivered is dropped and flagged.

---
 rtl/shift_deserializer_pkg.sv | 14 +
 rtl/shift_deserializer_word_holding_reg.sv | 62 ++++++
 rtl/shift_deserializer.sv | 103 ++++++++++
 tb/tb_shift_deserializer.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_deserializer_pkg.sv
// Shared constants for the serial-to-parallel deserializer stage.
// Bit-order encoding matches the upstream shift register's i_sht_lr input.
// FSM state encoding for the word assembly machine.
package shift_deserializer_pkg;

    // Bit order, same encoding as the upstream shift register direction.
    localparam logic ORDER_LSB_FIRST = 1'b1;
    localparam logic ORDER_MSB_FIRST = 1'b0;

    // Assembly FSM states.
    localparam logic [0:0] ST_IDLE    = 1'b0;
    localparam logic [0:0] ST_COLLECT = 1'b1;

endpackage

// File: rtl/shift_deserializer_word_holding_reg.sv
// One-entry valid/ready output register; loads completed words, flags dropped ones.
// Latency: a word loaded at edge N is visible with o_valid=1 from cycle N+1.
// Backpressure: a load while full and not being accepted is dropped; o_overrun is sticky.
// Ports: i_clr sync clear; i_load/i_load_data new word; i_ready consumer accept;
//        o_data/o_valid held word; o_overrun sticky drop flag.
module word_holding_reg #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_clr,
    input  logic         i_load,
    input  logic [W-1:0] i_load_data,
    input  logic         i_ready,
    output logic [W-1:0] o_data,
    output logic         o_valid,
    output logic         o_overrun
);

    logic [W-1:0] data_q, data_d;
    logic         valid_q, valid_d;
    logic         ovr_q, ovr_d;

    always_comb begin
        data_d  = data_q;
        valid_d = valid_q;
        ovr_d   = ovr_q;
        if (i_clr) begin
            data_d  = '0;
            valid_d = 1'b0;
            ovr_d   = 1'b0;
        end else if (i_load) begin
            // Room exists if empty, or if the held word leaves this same cycle.
            if (!valid_q || i_ready) begin
                data_d  = i_load_data;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end else if (valid_q && i_ready) begin
            // Data is left in place after acceptance; only valid drops.
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q  <= '0;
            valid_q <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            data_q  <= data_d;
            valid_q <= valid_d;
            ovr_q   <= ovr_d;
        end
    end

    assign o_data    = data_q;
    assign o_valid   = valid_q;
    assign o_overrun = ovr_q;

endmodule

// File: rtl/shift_deserializer.sv
// Rebuilds BUS_WIDTH-bit words from a qualified serial stream, LSB- or MSB-first.
// Latency: one cycle from the last bit of a word to o_data_valid.
// Backpressure: none toward the serial side; undeliverable words are dropped, o_overrun set.
// Ports: i_shift/i_valid serial input, i_sht_lr bit order (latched per word), i_clr sync clear;
//        o_data/o_data_valid/i_data_ready output handshake; o_busy, o_bit_cnt, o_overrun status.
module shift_deserializer
    import shift_deserializer_pkg::*;
#(
    parameter int BUS_WIDTH = 32,
    parameter int CNT_W     = $clog2(BUS_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 i_clr,
    input  logic                 i_sht_lr,
    input  logic                 i_shift,
    input  logic                 i_valid,
    output logic [BUS_WIDTH-1:0] o_data,
    output logic                 o_data_valid,
    input  logic                 i_data_ready,
    output logic                 o_busy,
    output logic [CNT_W-1:0]     o_bit_cnt,
    output logic                 o_overrun
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BUS_WIDTH - 1);

    logic [0:0]           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [BUS_WIDTH-1:0] sreg_q, sreg_d;
    logic                 order_q, order_d;
    logic                 busy_q, busy_d;
    logic                 order_eff;
    logic                 word_done;

    // The first bit of a word takes the live order; later bits use the latched one.
    assign order_eff = (state_q == ST_IDLE) ? i_sht_lr : order_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sreg_d    = sreg_q;
        order_d   = order_q;
        word_done = 1'b0;
        if (i_clr) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            sreg_d  = '0;
            order_d = ORDER_LSB_FIRST;
        end else if (i_valid) begin
            order_d = order_eff;
            if (order_eff == ORDER_LSB_FIRST) begin
                sreg_d = {i_shift, sreg_q[BUS_WIDTH-1:1]};
            end else begin
                sreg_d = {sreg_q[BUS_WIDTH-2:0], i_shift};
            end
            if (cnt_q == LAST_CNT) begin
                cnt_d     = '0;
                state_d   = ST_IDLE;
                word_done = 1'b1;
            end else begin
                cnt_d   = cnt_q + CNT_W'(1);
                state_d = ST_COLLECT;
            end
        end
        busy_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            sreg_q  <= '0;
            order_q <= ORDER_LSB_FIRST;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sreg_q  <= sreg_d;
            order_q <= order_d;
            busy_q  <= busy_d;
        end
    end

    // The completed word is the post-shift value, so it is handed over in the same cycle.
    word_holding_reg #(
        .W (BUS_WIDTH)
    ) u_hold (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_clr       (i_clr),
        .i_load      (word_done),
        .i_load_data (sreg_d),
        .i_ready     (i_data_ready),
        .o_data      (o_data),
        .o_valid     (o_data_valid),
        .o_overrun   (o_overrun)
    );

    assign o_busy    = busy_q;
    assign o_bit_cnt = cnt_q;

endmodule

// File: tb/tb_shift_deserializer.sv
module tb_shift_deserializer;

    localparam int W  = 8;
    localparam int CW = $clog2(W + 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_clr, i_sht_lr, i_shift, i_valid, i_data_ready;
    logic [W-1:0]  o_data;
    logic          o_data_valid, o_busy, o_overrun;
    logic [CW-1:0] o_bit_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: bits of the word in progress, in arrival order.
    bit       m_bits[$];
    bit       m_ord;
    bit       m_vld;
    bit [W-1:0] m_data;
    bit       m_ovr;

    shift_deserializer #(.BUS_WIDTH(W)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .i_clr        (i_clr),
        .i_sht_lr     (i_sht_lr),
        .i_shift      (i_shift),
        .i_valid      (i_valid),
        .o_data       (o_data),
        .o_data_valid (o_data_valid),
        .i_data_ready (i_data_ready),
        .o_busy       (o_busy),
        .o_bit_cnt    (o_bit_cnt),
        .o_overrun    (o_overrun)
    );

    always #5 clk = ~clk;

    function automatic logic [W+CW+2:0] dut_vec();
        return {o_data, o_data_valid, o_busy, o_bit_cnt, o_overrun};
    endfunction

    function automatic logic [W+CW+2:0] exp_vec();
        logic [CW-1:0] c;
        c = CW'(m_bits.size());
        return {m_data, m_vld, (m_bits.size() != 0), c, m_ovr};
    endfunction

    task automatic model_reset();
        m_bits.delete();
        m_ord  = 1'b1;
        m_vld  = 1'b0;
        m_data = '0;
        m_ovr  = 1'b0;
    endtask

    // Word assembled from the arrival list: LSB-first puts bit k at position k,
    // MSB-first puts bit k at position W-1-k.
    task automatic model_edge(input bit v, input bit b, input bit o, input bit r, input bit c);
        bit done;
        bit [W-1:0] w;
        done = 1'b0;
        w = '0;
        if (c) begin
            model_reset();
            return;
        end
        if (v) begin
            if (m_bits.size() == 0) m_ord = o;
            m_bits.push_back(b);
            if (m_bits.size() == W) begin
                for (int k = 0; k < W; k++) begin
                    if (m_ord) w[k] = m_bits[k];
                    else       w[W-1-k] = m_bits[k];
                end
                m_bits.delete();
                done = 1'b1;
            end
        end
        if (done) begin
            if (!m_vld || r) begin
                m_data = w;
                m_vld  = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_vld && r) begin
            m_vld = 1'b0;
        end
    endtask

    // Drive one cycle from a negedge, update the model at the posedge, return at the next negedge.
    task automatic step(input bit v, input bit b, input bit o, input bit r, input bit c);
        i_valid = v; i_shift = b; i_sht_lr = o; i_data_ready = r; i_clr = c;
        @(posedge clk);
        model_edge(v, b, o, r, c);
        @(negedge clk);
    endtask

    // Serial transmission of a word; mid-word order input is scrambled to show it is ignored.
    task automatic send_word(input bit [W-1:0] w, input bit ord, input bit r, input int gap);
        for (int k = 0; k < W; k++) begin
            bit b;
            b = ord ? w[k] : w[W-1-k];
            step(1'b1, b, (k == 0) ? ord : 1'($urandom), r, 1'b0);
            for (int g = 0; g < gap && k < W-1; g++) step(1'b0, 1'($urandom), 1'($urandom), r, 1'b0);
        end
    endtask

    task automatic test_reset();
        n_tests++;
        if ({o_data, o_data_valid, o_busy, o_bit_cnt, o_overrun} !== '0) begin
            n_fail++;
            $display("FAIL reset_state: got %h, want 0", dut_vec());
        end
    endtask

    task automatic test_lsb_first();
        send_word(8'h1E, 1'b1, 1'b1, 0);
        n_tests++;
        if (o_data !== 8'h1E || o_data_valid !== 1'b1 || o_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_1e: data=%h vld=%b busy=%b, want 1e 1 0", o_data, o_data_valid, o_busy);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (o_data_valid !== 1'b0 || o_data !== 8'h1E) begin
            n_fail++;
            $display("FAIL lsb_drain: vld=%b data=%h, want 0 1e", o_data_valid, o_data);
        end
    endtask

    task automatic test_msb_gaps();
        bit [W-1:0] w;
        int bad;
        w = 8'hB4;
        bad = 0;
        for (int k = 0; k < W; k++) begin
            step(1'b1, w[W-1-k], (k == 0) ? 1'b0 : 1'($urandom), 1'b1, 1'b0);
            for (int g = 0; g < 2 && k < W-1; g++) begin
                if (o_bit_cnt !== CW'(k + 1) || o_busy !== 1'b1) bad++;
                step(1'b0, 1'($urandom), 1'($urandom), 1'b1, 1'b0);
            end
            if (k < W-1 && (o_bit_cnt !== CW'(k + 1) || o_busy !== 1'b1)) bad++;
        end
        n_tests++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL msb_cnt_hold: %0d bad samples of cnt/busy, want 0", bad);
        end
        n_tests++;
        if (o_data !== 8'hB4 || o_data_valid !== 1'b1 || o_busy !== 1'b0 || o_bit_cnt !== '0) begin
            n_fail++;
            $display("FAIL msb_b4: data=%h vld=%b busy=%b cnt=%0d, want b4 1 0 0",
                     o_data, o_data_valid, o_busy, o_bit_cnt);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_overrun();
        send_word(8'h1E, 1'b1, 1'b0, 0);
        send_word(8'h55, 1'b1, 1'b0, 0);
        n_tests++;
        if (o_data !== 8'h1E || o_data_valid !== 1'b1 || o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_set: data=%h vld=%b ovr=%b, want 1e 1 1", o_data, o_data_valid, o_overrun);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        n_tests++;
        if (o_data_valid !== 1'b0 || o_overrun !== 1'b1) begin
            n_fail++;
            $display("FAIL overrun_sticky: vld=%b ovr=%b, want 0 1", o_data_valid, o_overrun);
        end
    endtask

    task automatic test_clear();
        bit [W-1:0] w;
        for (int k = 0; k < 3; k++) step(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
        n_tests++;
        if (o_bit_cnt !== '0 || o_busy !== 1'b0 || o_overrun !== 1'b0 || o_data_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL clear: cnt=%0d busy=%b ovr=%b vld=%b, want 0 0 0 0",
                     o_bit_cnt, o_busy, o_overrun, o_data_valid);
        end
        w = W'($urandom);
        send_word(w, 1'b0, 1'b1, 0);
        n_tests++;
        if (o_data !== w || o_data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL clear_next_word: data=%h vld=%b, want %h 1", o_data, o_data_valid, w);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        send_word(8'hFF, 1'b1, 1'b1, 0);
        for (int k = 0; k < 5; k++) step(1'b1, 1'($urandom), 1'b1, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({o_data, o_data_valid, o_busy, o_bit_cnt, o_overrun} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got %h, want 0", dut_vec());
        end
        model_reset();
        i_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        send_word(8'hA5, 1'b1, 1'b1, 0);
        n_tests++;
        if (o_data !== 8'hA5 || o_data_valid !== 1'b1 || o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset_a5: data=%h vld=%b ovr=%b, want a5 1 0", o_data, o_data_valid, o_overrun);
        end
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    endtask

    task automatic test_back_to_back();
        send_word(8'h01, 1'b1, 1'b1, 0);
        n_tests++;
        if (o_data !== 8'h01 || o_data_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_first: data=%h vld=%b, want 01 1", o_data, o_data_valid);
        end
        send_word(8'h80, 1'b1, 1'b1, 0);
        n_tests++;
        if (o_data !== 8'h80 || o_data_valid !== 1'b1 || o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: data=%h vld=%b ovr=%b, want 80 1 0", o_data, o_data_valid, o_overrun);
        end
        // Hold the first word until the exact cycle the second completes.
        step(1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
        send_word(8'h01, 1'b1, 1'b0, 0);
        for (int k = 0; k < W; k++) begin
            bit [W-1:0] w;
            w = 8'h80;
            step(1'b1, w[k], 1'b1, (k == W-1), 1'b0);
        end
        n_tests++;
        if (o_data !== 8'h80 || o_data_valid !== 1'b1 || o_overrun !== 1'b0) begin
            n_fail++;
            $display("FAIL accept_and_load: data=%h vld=%b ovr=%b, want 80 1 0", o_data, o_data_valid, o_overrun);
        end
        n_tests++;
        if (dut_vec() !== exp_vec()) begin
            n_fail++;
            $display("FAIL b2b_model: got %h, want %h", dut_vec(), exp_vec());
        end
    endtask

    task automatic test_random();
        int bad;
        bad = 0;
        for (int n = 0; n < 800; n++) begin
            step(($urandom_range(0, 9) < 7), 1'($urandom), 1'($urandom), 1'($urandom),
                 ($urandom_range(0, 99) < 2));
            n_tests++;
            if (dut_vec() !== exp_vec()) begin
                n_fail++;
                bad++;
                if (bad <= 10) $display("FAIL random_cycle_%0d: got %h, want %h", n, dut_vec(), exp_vec());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        i_clr = 1'b0; i_sht_lr = 1'b1; i_shift = 1'b0; i_valid = 1'b0; i_data_ready = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_lsb_first();
        test_msb_gaps();
        test_overrun();
        test_clear();
        test_async_reset();
        test_back_to_back();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
